wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Round-robin arbiter for the shared WISHBONE bus. Drives gnt_wb_i of each wb_master_interface (NIC master and core masters).
//  A master requests by raising CYC_O. The grant is held for the whole bus cycle, including pipelined/burst transfers.
//  owner_o selects the master-side mux for ADR/DAT/SEL/WE/STB.
//  A watchdog aborts any owner whose slave stops ACKing, using a one-hot ERR pulse.
// PARAMETERS
//  N_MASTERS       4   number of bus masters (>=2)
//  N_BITS_OWNER    2   width of owner_o (>= clog2(N_MASTERS))
//  TIMEOUT_CYCLES  64  max consecutive granted cycles without ACK_I; 0 disables the watchdog
//  N_BITS_TIMEOUT  7   width of the watchdog counter (must hold TIMEOUT_CYCLES)
// PORTS
//  clk         in   1             system clock, rising edge
//  rst_n       in   1             asynchronous active-low reset
//  cyc_i       in   N_MASTERS     CYC_O of each master, bit k = master k
//  ack_i       in   1             ACK from the bus slave side (muxed)
//  gnt_o       out  N_MASTERS     one-hot grant, registered
//  owner_o     out  N_BITS_OWNER  index of the granted master (valid while bus_busy_o)
//  bus_busy_o  out  1             high while any grant is active
//  err_o       out  N_MASTERS     one-hot watchdog abort pulse, ORed into the owner's ERR_I
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - gnt_o=0, owner_o=0, bus_busy_o=0, err_o=0.
//   - last_owner=N_MASTERS-1, so master 0 wins first. Watchdog count=0. State=IDLE.
//  Reset asserted mid-transfer: all outputs clear immediately; the in-flight transfer is abandoned.
//  All outputs are registered; no combinational path from input to output.
//  FSM:
//   IDLE
//    - If any cyc_i bit is set, choose the first set bit searching (last_owner+1) mod N upward, with wrap-around.
//    - On the next edge: gnt_o=onehot(sel), owner_o=sel, bus_busy_o=1 -> GRANT.
//    - Grant latency: 1 cycle after cyc_i is sampled high.
//   GRANT
//    - cyc_i of non-owners is ignored (no preemption).
//    - If cyc_i[owner]==0: -> RELEASE.
//    - Else, if the watchdog fires: err_o[owner]=1 for exactly one cycle -> RELEASE.
//   RELEASE
//    - gnt_o=0, bus_busy_o=0, err_o=0; last_owner<=owner -> IDLE.
//    - Guaranteed 1 idle cycle between owners.
//    - Minimum gap from CYC drop to the next grant: 3 edges.
//  Watchdog:
//   - Counter cleared on entry to GRANT and on every cycle with ack_i=1.
//   - Otherwise increments, saturating.
//   - Fires when count==TIMEOUT_CYCLES-1 and ack_i==0.
//   - ack_i takes priority in the same cycle.
//   - TIMEOUT_CYCLES==0: never fires.
//  Simultaneous events in GRANT:
//   - cyc_i[owner] drop takes priority over the watchdog; no err pulse.
//   - ack_i arriving together with the CYC drop is fine.
//  An aborted master still holding CYC re-enters arbitration like any other requester. If it is the sole requester it is re-granted.
//  Fairness: with all masters requesting continuously, grants rotate 0,1,2,3,0,...
//  owner_o holds its last value while idle; consumers qualify it with bus_busy_o.
// TESTING
//  1. Reset, then cyc_i=0001 at cycle 0 -> gnt_o=0001, owner_o=0, bus_busy_o=1 at cycle 1. Drop cyc -> gnt_o=0 two edges later.
//  2. cyc_i=1111 held (each master drops CYC after 4 cycles, then re-requests) -> grant order 0,1,2,3,0. One gnt_o=0 cycle between each pair.
//  3. Owner 2 granted; cyc_i[1] and cyc_i[3] rise mid-burst -> gnt_o stays 0100 until cyc_i[2]=0; next grant goes to 3, then 1.
//  4. TIMEOUT_CYCLES=8, owner 1 holds CYC with no ACK -> err_o=0010 for one cycle, 8 cycles after grant; then gnt_o=0.
//     Same run, but with ack_i every 7th cycle -> no err.
//  5. ack_i and watchdog expiry in the same cycle -> no err, counter clears.
//     cyc_i[owner] drop in the expiry cycle -> no err, normal RELEASE.
//  6. rst_n pulsed low mid-burst (async, between edges) -> gnt_o, bus_busy_o, err_o zero immediately.
//     After release with cyc_i=1010 -> master 1 granted first.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter with per-cycle grant hold and ACK watchdog.
// Grant, owner, busy and abort outputs are all registered.
module wb_bus_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int N_BITS_OWNER   = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int N_BITS_TIMEOUT = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_MASTERS-1:0]    cyc_i,
    input  logic                    ack_i,
    output logic [N_MASTERS-1:0]    gnt_o,
    output logic [N_BITS_OWNER-1:0] owner_o,
    output logic                    bus_busy_o,
    output logic [N_MASTERS-1:0]    err_o
);

    localparam int LP_IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    localparam logic [N_MASTERS-1:0] LP_ONE = N_MASTERS'(1);

    localparam logic [N_BITS_OWNER-1:0] LP_LAST_RST =
        N_BITS_OWNER'(N_MASTERS - 1);

    localparam bit LP_WD_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [N_BITS_TIMEOUT-1:0] LP_WD_LAST =
        (TIMEOUT_CYCLES > 0) ? N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1)
                             : '0;

    localparam logic [N_BITS_TIMEOUT-1:0] LP_WD_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [N_MASTERS-1:0]      r_gnt;
    logic [N_BITS_OWNER-1:0]   r_owner;
    logic                      r_busy;
    logic [N_MASTERS-1:0]      r_err;
    logic [N_BITS_OWNER-1:0]   r_last;
    logic [N_BITS_TIMEOUT-1:0] r_wd;

    state_t                    w_state_nxt;
    logic [N_MASTERS-1:0]      w_gnt_nxt;
    logic [N_BITS_OWNER-1:0]   w_owner_nxt;
    logic                      w_busy_nxt;
    logic [N_MASTERS-1:0]      w_err_nxt;
    logic [N_BITS_OWNER-1:0]   w_last_nxt;
    logic [N_BITS_TIMEOUT-1:0] w_wd_nxt;

    logic [LP_IW-1:0]          w_idx;
    logic [N_BITS_OWNER-1:0]   w_sel;
    logic                      w_found;
    logic [LP_IW-1:0]          w_own_idx;
    logic                      w_own_req;
    logic                      w_wd_fire;

    // Search starts one past the previous owner so every requester
    // is reached within N_MASTERS grants.
    always_comb begin
        w_idx   = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            w_idx = LP_IW'((int'(r_last) + i) % N_MASTERS);
            if (!w_found && cyc_i[w_idx]) begin
                w_found = 1'b1;
                w_sel   = N_BITS_OWNER'(w_idx);
            end
        end
    end

    assign w_own_idx = LP_IW'(r_owner);
    assign w_own_req = cyc_i[w_own_idx];

    assign w_wd_fire = LP_WD_EN && !ack_i && (r_wd == LP_WD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_err_nxt   = '0;
        w_last_nxt  = r_last;
        w_wd_nxt    = r_wd;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = LP_ONE << w_sel;
                    w_owner_nxt = w_sel;
                    w_busy_nxt  = 1'b1;
                    w_wd_nxt    = '0;
                end
            end
            S_GRANT: begin
                if (ack_i) begin
                    w_wd_nxt = '0;
                end else if (r_wd != LP_WD_MAX) begin
                    w_wd_nxt = r_wd + 1'b1;
                end
                // A voluntary CYC drop wins over an expiring watchdog.
                if (!w_own_req) begin
                    w_state_nxt = S_RELEASE;
                end else if (w_wd_fire) begin
                    w_err_nxt   = LP_ONE << r_owner;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_last_nxt  = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_err   <= '0;
            r_last  <= LP_LAST_RST;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_last  <= w_last_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    assign gnt_o      = r_gnt;
    assign owner_o    = r_owner;
    assign bus_busy_o = r_busy;
    assign err_o      = r_err;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Random-master bench for wb_bus_arbiter with a transaction-level
// reference model feeding a per-cycle scoreboard.
module tb_wb_bus_arbiter;

    localparam int NM  = 4;
    localparam int NB  = 2;
    localparam int TO  = 8;
    localparam int NBT = 7;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NM-1:0] cyc   = '0;
    logic          ack   = 1'b0;
    logic [NM-1:0] gnt_o;
    logic [NB-1:0] owner_o;
    logic          bus_busy_o;
    logic [NM-1:0] err_o;

    always #5 clk = ~clk;

    wb_bus_arbiter #(
        .N_MASTERS     (NM),
        .N_BITS_OWNER  (NB),
        .TIMEOUT_CYCLES(TO),
        .N_BITS_TIMEOUT(NBT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cyc_i     (cyc),
        .ack_i     (ack),
        .gnt_o     (gnt_o),
        .owner_o   (owner_o),
        .bus_busy_o(bus_busy_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic [NM-1:0] gnt;
        logic [NB-1:0] owner;
        logic          busy;
        logic [NM-1:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic bit bit_of(logic [NM-1:0] v, int k);
        return ((v >> k) & NM'(1)) != '0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: who holds the bus, how many granted cycles have gone by
    // without an ACK, and whether the current tenancy is winding down.
    exp_t m_out     = '0;
    int   m_own     = 0;
    int   m_last    = NM - 1;
    int   m_quiet   = 0;
    bit   m_held    = 1'b0;
    bit   m_closing = 1'b0;
    int   m_k       = 0;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_out     = '0;
                m_own     = 0;
                m_last    = NM - 1;
                m_quiet   = 0;
                m_held    = 1'b0;
                m_closing = 1'b0;
                sb_q.delete();
            end else begin
                m_out.err = '0;
                if (m_closing) begin
                    m_out.gnt  = '0;
                    m_out.busy = 1'b0;
                    m_last     = m_own;
                    m_held     = 1'b0;
                    m_closing  = 1'b0;
                end else if (m_held) begin
                    if (!bit_of(cyc, m_own)) begin
                        m_closing = 1'b1;
                    end else if (ack) begin
                        m_quiet = 0;
                    end else if (m_quiet + 1 == TO) begin
                        m_out.err = NM'(1) << m_own;
                        m_closing = 1'b1;
                    end else begin
                        m_quiet++;
                    end
                end else begin
                    for (int i = 1; i <= NM; i++) begin
                        m_k = (m_last + i) % NM;
                        if (bit_of(cyc, m_k)) begin
                            m_own       = m_k;
                            m_held      = 1'b1;
                            m_quiet     = 0;
                            m_out.gnt   = NM'(1) << m_k;
                            m_out.owner = NB'(m_k);
                            m_out.busy  = 1'b1;
                            break;
                        end
                    end
                end
                sb_q.push_back(m_out);
            end
        end
    end

    exp_t mon_e;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({gnt_o, owner_o, bus_busy_o, err_o} !== mon_e) begin
                        errors++;
                        $display("FAIL cycle@%0t gnt=%b owner=%0d busy=%b err=%b want gnt=%b owner=%0d busy=%b err=%b",
                                 $time, gnt_o, owner_o, bus_busy_o, err_o,
                                 mon_e.gnt, mon_e.owner, mon_e.busy,
                                 mon_e.err);
                    end
                end
            end
        end
    end

    int len[NM];
    int gap[NM];
    int p_req   = 0;
    int p_ack   = 0;
    int ack_per = 0;
    int len_min = 1;
    int len_max = 1;
    int gap_max = 0;
    int cyc_n   = 0;

    // Masters hold CYC until their burst completes; an aborted master
    // randomly either gives up or keeps requesting.
    task automatic step();
        @(negedge clk);
        cyc_n++;
        for (int k = 0; k < NM; k++) begin
            if (bit_of(cyc, k)) begin
                if (bit_of(gnt_o, k)) begin
                    len[k]--;
                    if (len[k] <= 0 ||
                        (bit_of(err_o, k) && $urandom_range(1) == 1)) begin
                        cyc[k] = 1'b0;
                        gap[k] = int'($urandom_range(gap_max, 0));
                    end
                end
            end else if (gap[k] > 0) begin
                gap[k]--;
            end else if (int'($urandom_range(99)) < p_req) begin
                cyc[k] = 1'b1;
                len[k] = int'($urandom_range(len_max, len_min));
            end
        end
        if (ack_per > 0) ack = (cyc_n % ack_per) == 0;
        else ack = int'($urandom_range(99)) < p_ack;
    endtask

    task automatic phase(int pr, int pa, int per, int lmin, int lmax,
                         int gmax, int n);
        p_req   = pr;
        p_ack   = pa;
        ack_per = per;
        len_min = lmin;
        len_max = lmax;
        gap_max = gmax;
        repeat (n) step();
    endtask

    int n_wait;

    initial begin : stim
        for (int k = 0; k < NM; k++) begin
            len[k] = 0;
            gap[k] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        chk("rst_busy", 32'(bus_busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;

        phase(30, 70, 0, 1, 12, 6, 500);
        phase(40, 5, 0, 1, 20, 4, 600);
        phase(100, 100, 0, 4, 4, 0, 200);
        phase(50, 0, 7, 10, 30, 3, 400);
        phase(50, 0, 9, 10, 30, 3, 300);
        phase(30, 50, 0, 1, 15, 5, 500);

        p_req   = 60;
        p_ack   = 60;
        ack_per = 0;
        n_wait  = 0;
        while (bus_busy_o !== 1'b1 && n_wait < 200) begin
            step();
            n_wait++;
        end
        chk("busy_before_rst", 32'(bus_busy_o), 32'd1);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt_o), 32'd0);
        chk("async_busy", 32'(bus_busy_o), 32'd0);
        chk("async_err", 32'(err_o), 32'd0);
        chk("async_owner", 32'(owner_o), 32'd0);

        @(negedge clk);
        cyc = '0;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NM; k++) begin
            len[k] = 3;
            gap[k] = 1000;
        end
        cyc   = 4'b1010;
        rst_n = 1'b1;
        phase(0, 50, 0, 1, 1, 0, 30);
        phase(35, 40, 0, 1, 16, 5, 300);

        cyc = '0;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
